switch_input_ctrl: RTL and testbench



---
 rtl/switch_input_ctrl.sv | 102 ++++++++++
 tb/tb_switch_input_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_input_ctrl.sv
// DIP-switch input peripheral: two-flop sync, tick-sampled debounce, sticky W1C edge flags.
// Optional SW_IRQ_EN adds a MASK register and a level interrupt; without it irq is tied low.
module switch_input_ctrl #(
  parameter int WIDTH      = 32,
  parameter int DEB_CYCLES = 250000,
  parameter int CNT_W      = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  input  logic [1:0]       addr,
  input  logic             WE,
  input  logic [31:0]      din,
  output logic [31:0]      RD,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] samp_reg;
  logic [WIDTH-1:0] stable_reg;
  logic [WIDTH-1:0] stable_next;
  logic [WIDTH-1:0] edge_flags_reg;
  logic [WIDTH-1:0] edge_flags_next;
  logic [WIDTH-1:0] qualify;
  logic [WIDTH-1:0] edge_clr;
  logic [CNT_W-1:0] cnt_reg;
  logic             tick;

  assign tick = (cnt_reg == CNT_W'(DEB_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign edge_clr = (WE && addr == 2'd1) ? din[WIDTH-1:0] : '0;

  // A level is accepted only after it has been seen on two consecutive ticks.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign qualify[gi]         = tick && (sync2_reg[gi] == samp_reg[gi])
                                        && (sync2_reg[gi] != stable_reg[gi]);
      assign stable_next[gi]     = qualify[gi] ? sync2_reg[gi] : stable_reg[gi];
      // A new qualification overrides a simultaneous clear.
      assign edge_flags_next[gi] = qualify[gi] | (edge_flags_reg[gi] & ~edge_clr[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg      <= '0;
      sync2_reg      <= '0;
      samp_reg       <= '0;
      stable_reg     <= '0;
      edge_flags_reg <= '0;
    end else begin
      sync1_reg      <= sw_in;
      sync2_reg      <= sync1_reg;
      if (tick) begin
        samp_reg <= sync2_reg;
      end
      stable_reg     <= stable_next;
      edge_flags_reg <= edge_flags_next;
    end
  end

`ifdef SW_IRQ_EN
  logic [WIDTH-1:0] mask_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_reg <= '0;
    end else if (WE && addr == 2'd2) begin
      mask_reg <= din[WIDTH-1:0];
    end
  end

  assign irq = |(edge_flags_reg & mask_reg);
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    RD = '0;
    case (addr)
      2'd0: RD[WIDTH-1:0] = stable_reg;
      2'd1: RD[WIDTH-1:0] = edge_flags_reg;
`ifdef SW_IRQ_EN
      2'd2: RD[WIDTH-1:0] = mask_reg;
`endif
      default: RD = '0;
    endcase
  end

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Directed bench for switch_input_ctrl (WIDTH=8, DEB_CYCLES=4, CNT_W=3).
// Expected irq/MASK values follow SW_IRQ_EN when the bench is compiled with it.
module tb_switch_input_ctrl;

  localparam int WIDTH = 8;
  localparam int DEB   = 4;
`ifdef SW_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] sw_in;
  logic [1:0]       addr;
  logic             WE;
  logic [31:0]      din;
  logic [31:0]      RD;
  logic             irq;

  int vectors     = 0;
  int miscompares = 0;
  int m_cnt       = 0;

  switch_input_ctrl #(.WIDTH(WIDTH), .DEB_CYCLES(DEB), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .sw_in (sw_in),
    .addr  (addr),
    .WE    (WE),
    .din   (din),
    .RD    (RD),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference prescaler: m_cnt==DEB-1 at a negedge means the next posedge is a tick.
  always @(posedge clk) begin
    if (reset) m_cnt <= 0;
    else       m_cnt <= (m_cnt == DEB - 1) ? 0 : m_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    #1;
    chk(tag, RD, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    WE   = 1'b1;
    addr = a;
    din  = d;
    $display("wr addr=%0d din=%h", a, d);
    @(negedge clk);
    WE = 1'b0;
  endtask

  // Advance to the negedge just before the next tick edge.
  task automatic to_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_cnt != DEB - 1 && n < 20);
    if (m_cnt != DEB - 1) begin
      miscompares++;
      $display("FAIL tick_wait: got no tick within %0d cycles expected tick", n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    sw_in = 8'hA5;
    WE    = 1'b0;
    addr  = 2'd0;
    din   = '0;

    // 1: reset state, then qualification of switches held across reset
    repeat (3) @(negedge clk);
    rd_chk(2'd0, 32'h0, "rst_data");
    rd_chk(2'd1, 32'h0, "rst_edge");
    rd_chk(2'd2, 32'h0, "rst_mask");
    chk("rst_irq", irq, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    rd_chk(2'd0, 32'h0, "t1_data_c1");
    @(negedge clk);
    rd_chk(2'd0, 32'h0, "t1_data_c2");
    repeat (9) @(negedge clk);
    rd_chk(2'd0, 32'hA5, "t1_data_c11");
    rd_chk(2'd1, 32'hA5, "t1_edge");
    chk("t1_irq", irq, 1'b0);

    // 2: one-cycle glitch on bit1 is rejected
    to_tick();
    @(negedge clk);
    sw_in = 8'hA7;
    @(negedge clk);
    sw_in = 8'hA5;
    repeat (12) @(negedge clk);
    rd_chk(2'd0, 32'hA5, "t2_data");
    rd_chk(2'd1, 32'hA5, "t2_edge");

    // 3: W1C on EDGE, DATA and reserved writes ignored
    wr(2'd1, 32'h05);
    rd_chk(2'd1, 32'hA0, "t3_edge_w1c");
    wr(2'd0, 32'hFF);
    rd_chk(2'd0, 32'hA5, "t3_data_ro");
    wr(2'd3, 32'hFF);
    rd_chk(2'd3, 32'h0, "t3_rsvd");

    // 4: bit3 rise, then its fall qualifies on the same edge as a W1C of bit3
    to_tick();
    @(negedge clk);
    sw_in = 8'hAD;
    to_tick();
    to_tick();
    @(negedge clk);
    rd_chk(2'd0, 32'hAD, "t4_data_rise");
    rd_chk(2'd1, 32'hA8, "t4_edge_rise");
    wr(2'd1, 32'hFF);
    rd_chk(2'd1, 32'h0, "t4_edge_clr");
    to_tick();
    @(negedge clk);
    sw_in = 8'hA5;
    to_tick();
    to_tick();
    WE   = 1'b1;
    addr = 2'd1;
    din  = 32'h08;
    $display("wr addr=1 din=%h (on fall tick)", din);
    @(negedge clk);
    WE = 1'b0;
    rd_chk(2'd1, 32'h08, "t4_set_wins");
    rd_chk(2'd0, 32'hA5, "t4_data_fall");

    // 5: MASK and irq
    wr(2'd2, 32'h80);
    rd_chk(2'd2, IRQ_ON ? 32'h80 : 32'h0, "t5_mask_rb");
    chk("t5_irq_idle", irq, 1'b0);
    to_tick();
    @(negedge clk);
    sw_in = 8'h25;
    to_tick();
    to_tick();
    chk("t5_irq_pre", irq, 1'b0);
    @(negedge clk);
    chk("t5_irq_set", irq, IRQ_ON);
    rd_chk(2'd1, 32'h88, "t5_edge");
    wr(2'd1, 32'h80);
    chk("t5_irq_clr", irq, 1'b0);
    rd_chk(2'd1, 32'h08, "t5_edge_clr");

    // 6: reset one tick into a 00->0F change
    sw_in = 8'h00;
    to_tick();
    to_tick();
    to_tick();
    @(negedge clk);
    rd_chk(2'd0, 32'h0, "t6_data_zero");
    to_tick();
    @(negedge clk);
    sw_in = 8'h0F;
    to_tick();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd_chk(2'd0, 32'h0, "t6_rst_data");
    rd_chk(2'd1, 32'h0, "t6_rst_edge");
    rd_chk(2'd2, 32'h0, "t6_rst_mask");
    chk("t6_rst_irq", irq, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    rd_chk(2'd0, 32'h0, "t6_data_c1");
    repeat (10) @(negedge clk);
    rd_chk(2'd0, 32'h0F, "t6_data_c11");
    rd_chk(2'd1, 32'h0F, "t6_edge_c11");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
